// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. It owns the PC and runs a
// single-outstanding req/gnt/rvalid handshake to instruction memory.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic [6:0]  ifid_opcode
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_next;
    logic [31:0] r_hold_pc;
    logic [31:0] w_hold_pc_next;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_instr_next;

    logic        r_ifid_valid;
    logic        w_ifid_valid_next;
    logic [31:0] r_ifid_pc;
    logic [31:0] w_ifid_pc_next;
    logic [31:0] r_ifid_pc4;
    logic [31:0] w_ifid_pc4_next;
    logic [31:0] r_ifid_instr;
    logic [31:0] w_ifid_instr_next;

    logic        w_load;
    logic [31:0] w_load_pc;
    logic [31:0] w_load_instr;
    logic        w_outstanding;

    // A request is still in flight if it was granted now or its response has not arrived.
    assign w_outstanding = ((r_state == S_REQ) && imem_gnt) ||
                           ((r_state == S_RESP) && !imem_rvalid) ||
                           ((r_state == S_DROP) && !imem_rvalid);

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_pc_next     = r_req_pc;
        w_hold_pc_next    = r_hold_pc;
        w_hold_instr_next = r_hold_instr;
        w_load            = 1'b0;
        w_load_pc         = r_req_pc;
        w_load_instr      = imem_rdata;

        case (r_state)
            S_REQ: begin
                if (imem_gnt) begin
                    w_req_pc_next = r_pc;
                    w_pc_next     = r_pc + 32'd4;
                    w_state_next  = S_RESP;
                end
            end
            S_RESP: begin
                if (imem_rvalid) begin
                    if (!stall_i) begin
                        w_load       = 1'b1;
                        w_state_next = S_REQ;
                    end else begin
                        w_hold_pc_next    = r_req_pc;
                        w_hold_instr_next = imem_rdata;
                        w_state_next      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_hold_pc;
                    w_load_instr = r_hold_instr;
                    w_state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase

        w_ifid_valid_next = r_ifid_valid;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_pc4_next   = r_ifid_pc4;
        w_ifid_instr_next = r_ifid_instr;
        if (w_load) begin
            w_ifid_valid_next = 1'b1;
            w_ifid_pc_next    = w_load_pc;
            w_ifid_pc4_next   = w_load_pc + 32'd4;
            w_ifid_instr_next = w_load_instr;
        end else if (!stall_i) begin
            w_ifid_valid_next = 1'b0;
            w_ifid_instr_next = NOP_INSTR;
        end

        // Redirect beats everything, including a stall from the hazard unit.
        if (redirect_i) begin
            w_pc_next         = {redirect_pc_i[31:2], 2'b00};
            w_ifid_valid_next = 1'b0;
            w_ifid_instr_next = NOP_INSTR;
            w_hold_pc_next    = 32'd0;
            w_hold_instr_next = NOP_INSTR;
            w_state_next      = w_outstanding ? S_DROP : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_pc     <= w_req_pc_next;
            r_hold_pc    <= w_hold_pc_next;
            r_hold_instr <= w_hold_instr_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_pc4   <= w_ifid_pc4_next;
            r_ifid_instr <= w_ifid_instr_next;
        end
    end

    // Request is gated by reset so the bus is quiet while rst_n is low.
    assign imem_req    = rst_n && (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign ifid_valid  = r_ifid_valid;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_opcode = r_ifid_instr[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, streaming, stall/hold,
// redirect squash, redirect+stall in HOLD, wait states and PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        imem_req,   w_req_b;
    logic [31:0] imem_addr,  w_addr_b;
    logic        ifid_valid, w_valid_b;
    logic [31:0] ifid_pc,    w_pc_b;
    logic [31:0] ifid_pc4,   w_pc4_b;
    logic [31:0] ifid_instr, w_instr_b;
    logic [6:0]  ifid_opcode, w_opcode_b;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode)
    );

    // Second instance starts at the top of the address space to exercise PC wrap.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req_b), .imem_addr(w_addr_b),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifid_valid(w_valid_b), .ifid_pc(w_pc_b), .ifid_pc4(w_pc4_b),
        .ifid_instr(w_instr_b), .ifid_opcode(w_opcode_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_gnt();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
    endtask

    task automatic do_rv(input logic [31:0] addr);
        imem_rvalid = 1'b1;
        imem_rdata  = addr ^ KEY;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc);
        logic [31:0] word;
        word = pc ^ KEY;
        check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
        check({tag, "_pc"}, ifid_pc, pc);
        check({tag, "_pc4"}, ifid_pc4, pc + 32'd4);
        check({tag, "_instr"}, ifid_instr, word);
        check({tag, "_opc"}, {25'd0, ifid_opcode}, {25'd0, word[6:0]});
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_pc", ifid_pc, 32'd0);
        check("rst_pc4", ifid_pc4, 32'd0);
        check("rst_instr", ifid_instr, NOP);
        rst_n = 1'b1;
        #1;
        check("c1_req", {31'd0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'd0);
        check("wrap_addr0", w_addr_b, 32'hFFFF_FFFC);

        // Streaming, zero-wait memory
        do_gnt();
        check("s0_req", {31'd0, imem_req}, 32'd0);
        check("s0_instr", ifid_instr, NOP);
        do_rv(32'd0);
        check_ifid("s0", 32'd0);
        check("s0_next", imem_addr, 32'd4);
        check("wrap_addr1", w_addr_b, 32'd0);
        check("wrap_pc4", w_pc4_b, 32'd0);
        do_gnt();
        check("s1_bubble", {31'd0, ifid_valid}, 32'd0);
        do_rv(32'd4);
        check_ifid("s1", 32'd4);

        // Stall during the rvalid of pc 8, held 3 cycles
        do_gnt();
        stall_i = 1'b1;
        do_rv(32'd8);
        for (int i = 0; i < 3; i++) begin
            check("st_req", {31'd0, imem_req}, 32'd0);
            check("st_pc", ifid_pc, 32'd4);
            check("st_valid", {31'd0, ifid_valid}, 32'd0);
            if (i == 2) stall_i = 1'b0;
            if (i < 2) tick();
        end
        tick();
        check_ifid("st_rel", 32'd8);
        check("st_next", imem_addr, 32'd12);

        // Redirect with a request outstanding
        do_gnt();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0; redirect_pc_i = 32'd0;
        check("rd_req", {31'd0, imem_req}, 32'd0);
        check("rd_valid", {31'd0, ifid_valid}, 32'd0);
        check("rd_instr", ifid_instr, NOP);
        tick();
        check("rd_wait_req", {31'd0, imem_req}, 32'd0);
        do_rv(32'd12);
        check("rd_drop_vld", {31'd0, ifid_valid}, 32'd0);
        check("rd_drop_ins", ifid_instr, NOP);
        check("rd_req2", {31'd0, imem_req}, 32'd1);
        check("rd_addr", imem_addr, 32'h0000_0100);

        // Redirect and stall together while in HOLD
        do_gnt();
        do_rv(32'h100);
        check_ifid("h0", 32'h100);
        stall_i = 1'b1;
        do_gnt();
        check("h_keep_pc", ifid_pc, 32'h100);
        check("h_keep_vld", {31'd0, ifid_valid}, 32'd1);
        do_rv(32'h104);
        check("h_req", {31'd0, imem_req}, 32'd0);
        check("h_keep_ins", ifid_instr, 32'h100 ^ KEY);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0; stall_i = 1'b0; redirect_pc_i = 32'd0;
        check("hr_valid", {31'd0, ifid_valid}, 32'd0);
        check("hr_instr", ifid_instr, NOP);
        check("hr_req", {31'd0, imem_req}, 32'd1);
        check("hr_addr", imem_addr, 32'h0000_0200);

        // Wait states: gnt withheld 4 cycles, address must stay put
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ws_req", {31'd0, imem_req}, 32'd1);
            check("ws_addr", imem_addr, 32'h0000_0200);
            check("ws_bubble", {31'd0, ifid_valid}, 32'd0);
        end
        do_gnt();
        check("ws_gnt_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("ws_resp_vld", {31'd0, ifid_valid}, 32'd0);
        do_rv(32'h200);
        check_ifid("ws", 32'h200);
        check("ws_next", imem_addr, 32'h0000_0204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
